// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC, imem req/ready handshake, captured word for the decoder, jump/branch redirect.
// Optional FETCH_ALIGN_CHECK_EN: misaligned redirect raises sticky fetch_fault and halts fetching.
module fetch_unit #(
  parameter int            AW       = 32,
  parameter logic [AW-1:0] RESET_PC = '0
) (
  input  logic          clk,
  input  logic          rst_n,
  output logic          imem_req,
  output logic [AW-1:0] imem_addr,
  input  logic          imem_ready,
  input  logic [31:0]   imem_rdata,
  output logic [31:0]   instr,
  output logic [5:0]    op,
  output logic [5:0]    funct,
  output logic          instr_valid,
  output logic [AW-1:0] pc,
  output logic [AW-1:0] pc_plus4,
  input  logic          stall,
  input  logic          jump,
  input  logic [25:0]   jump_index,
  input  logic          branch_taken,
  input  logic [AW-1:0] branch_target,
  output logic          fetch_fault
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_VALID, S_HALT} state_e;

  state_e        state_q, state_d;
  logic [AW-1:0] fetch_pc_q, fetch_pc_d;
  logic [AW-1:0] pc_q, pc_d;
  logic [31:0]   instr_q, instr_d;
  logic          valid_q, valid_d;
  logic          fault_q, fault_d;
  logic [AW-1:0] redirect_pc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      fetch_pc_q <= RESET_PC;
      pc_q       <= RESET_PC;
      instr_q    <= '0;
      valid_q    <= 1'b0;
      fault_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      pc_q       <= pc_d;
      instr_q    <= instr_d;
      valid_q    <= valid_d;
      fault_q    <= fault_d;
    end
  end

  assign pc_plus4 = pc_q + AW'(4);

  // Jump beats branch when both are asserted for the same word.
  assign redirect_pc = jump         ? {pc_plus4[AW-1:28], jump_index, 2'b00} :
                       branch_taken ? branch_target : pc_plus4;

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    pc_d       = pc_q;
    instr_d    = instr_q;
    valid_d    = valid_q;
    fault_d    = fault_q;
    unique case (state_q)
      S_IDLE: state_d = S_REQ;
      S_REQ: begin
        if (imem_ready) begin
          instr_d = imem_rdata;
          pc_d    = fetch_pc_q;
          valid_d = 1'b1;
          state_d = S_VALID;
        end
      end
      S_VALID: begin
        if (!stall) begin
          valid_d = 1'b0;
`ifdef FETCH_ALIGN_CHECK_EN
          if (redirect_pc[1:0] != 2'b00) begin
            fault_d = 1'b1;
            state_d = S_HALT;
          end else begin
            fetch_pc_d = redirect_pc;
            state_d    = S_REQ;
          end
`else
          fetch_pc_d = redirect_pc & ~AW'(3);
          state_d    = S_REQ;
`endif
        end
      end
      S_HALT: valid_d = 1'b0;
      default: state_d = S_IDLE;
    endcase
  end

  // Request is a decode of the registered state, so it drops as soon as reset asserts.
  assign imem_req    = (state_q == S_REQ);
  assign imem_addr   = fetch_pc_q;
  assign instr       = instr_q;
  assign op          = instr_q[31:26];
  assign funct       = instr_q[5:0];
  assign instr_valid = valid_q;
  assign pc          = pc_q;
  assign fetch_fault = fault_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed vector table, hand sequences, randomized redirects vs a reference model.
module tb_fetch_unit;
  localparam int          AW       = 32;
  localparam logic [31:0] RESET_PC = 32'h0;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic [31:0] instr;
  logic [5:0]  op;
  logic [5:0]  funct;
  logic        instr_valid;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        stall;
  logic        jump;
  logic [25:0] jump_index;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic        fetch_fault;

  int tests  = 0;
  int errors = 0;
  logic [31:0] exp_addr;

  fetch_unit #(.AW(AW), .RESET_PC(RESET_PC)) dut (
    .clk(clk), .rst_n(rst_n), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ready(imem_ready), .imem_rdata(imem_rdata), .instr(instr), .op(op),
    .funct(funct), .instr_valid(instr_valid), .pc(pc), .pc_plus4(pc_plus4),
    .stall(stall), .jump(jump), .jump_index(jump_index), .branch_taken(branch_taken),
    .branch_target(branch_target), .fetch_fault(fetch_fault)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          dly;
    int          stl;
    logic        j;
    logic [25:0] ji;
    logic        b;
    logic [31:0] bt;
    logic [31:0] nxt;
  } vec_t;

  vec_t vecs[16];

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  function automatic logic [31:0] ref_next(input logic [31:0] cur, input logic j,
                                           input logic [25:0] ji, input logic b,
                                           input logic [31:0] bt);
    logic [31:0] p4;
    p4 = cur + 32'd4;
    if (j)      return {p4[31:28], ji, 2'b00};
    else if (b) return bt;
    else        return p4;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_fetch(input int dly, input int stl, input logic j, input logic [25:0] ji,
                          input logic b, input logic [31:0] bt);
    logic [31:0] a, w;
    int n;
    bit ok;
    n = 0;
    while (!imem_req && n < 20) begin
      tick();
      n++;
    end
    chk("req_seen", {31'b0, imem_req}, 32'd1);
    a = imem_addr;
    chk("imem_addr", a, exp_addr);
    ok = 1;
    for (int i = 0; i < dly; i++) begin
      tick();
      if (!imem_req || imem_addr !== a || instr_valid) ok = 0;
    end
    chk("req_hold", {31'b0, ok}, 32'd1);
    w = mem_word(a);
    imem_ready = 1'b1;
    imem_rdata = w;
    tick();
    imem_ready = 1'b0;
    imem_rdata = $urandom;
    chk("valid", {31'b0, instr_valid}, 32'd1);
    chk("instr", instr, w);
    chk("op", {26'b0, op}, {26'b0, w[31:26]});
    chk("funct", {26'b0, funct}, {26'b0, w[5:0]});
    chk("pc", pc, a);
    chk("pc_plus4", pc_plus4, a + 32'd4);
    chk("req_drop", {31'b0, imem_req}, 32'd0);
    // Redirects and a stray ready during stall must all be ignored.
    stall = 1'b1; jump = 1'b1; branch_taken = 1'b1; imem_ready = 1'b1;
    jump_index = 26'($urandom); branch_target = $urandom;
    ok = 1;
    for (int i = 0; i < stl; i++) begin
      tick();
      if (instr !== w || pc !== a || !instr_valid || imem_req) ok = 0;
    end
    chk("stall_hold", {31'b0, ok}, 32'd1);
    stall = 1'b0; imem_ready = 1'b0;
    jump = j; jump_index = ji; branch_taken = b; branch_target = bt;
    tick();
    jump = 1'b0; branch_taken = 1'b0;
    chk("accept_drop", {31'b0, instr_valid}, 32'd0);
  endtask

  initial begin
    vecs[0]  = '{0, 0, 1'b0, 26'h0,       1'b0, 32'h0,         32'h0000_0004};
    vecs[1]  = '{3, 0, 1'b0, 26'h0,       1'b0, 32'h0,         32'h0000_0008};
    vecs[2]  = '{0, 0, 1'b0, 26'h0,       1'b0, 32'h0,         32'h0000_000C};
    vecs[3]  = '{1, 0, 1'b0, 26'h0,       1'b1, 32'h0040_0008, 32'h0040_0008};
    vecs[4]  = '{0, 5, 1'b1, 26'h10,      1'b0, 32'h0,         32'h0000_0040};
    vecs[5]  = '{0, 0, 1'b0, 26'h0,       1'b0, 32'h0,         32'h0000_0044};
    vecs[6]  = '{2, 1, 1'b0, 26'h0,       1'b1, 32'h0000_0020, 32'h0000_0020};
    vecs[7]  = '{0, 0, 1'b0, 26'h0,       1'b1, 32'h0000_0100, 32'h0000_0100};
    vecs[8]  = '{0, 0, 1'b0, 26'h0,       1'b1, 32'h0000_0020, 32'h0000_0020};
    vecs[9]  = '{0, 0, 1'b1, 26'h55,      1'b1, 32'h0000_0100, 32'h0000_0154};
    vecs[10] = '{0, 0, 1'b1, 26'h3FF_FFFF, 1'b0, 32'h0,        32'h0FFF_FFFC};
    vecs[11] = '{0, 0, 1'b0, 26'h0,       1'b0, 32'h0,         32'h1000_0000};
    vecs[12] = '{0, 0, 1'b1, 26'h1,       1'b0, 32'h0,         32'h1000_0004};
    vecs[13] = '{0, 0, 1'b0, 26'h0,       1'b1, 32'hFFFF_FFFC, 32'hFFFF_FFFC};
    vecs[14] = '{1, 0, 1'b0, 26'h0,       1'b0, 32'h0,         32'h0000_0000};
    vecs[15] = '{0, 2, 1'b0, 26'h0,       1'b0, 32'h0,         32'h0000_0004};

    rst_n = 1'b0; imem_ready = 1'b0; imem_rdata = '0; stall = 1'b0;
    jump = 1'b0; jump_index = '0; branch_taken = 1'b0; branch_target = '0;
    #23;
    chk("rst_req", {31'b0, imem_req}, 32'd0);
    chk("rst_valid", {31'b0, instr_valid}, 32'd0);
    chk("rst_instr", instr, 32'd0);
    chk("rst_fault", {31'b0, fetch_fault}, 32'd0);
    chk("rst_addr", imem_addr, RESET_PC);
    tick();
    rst_n = 1'b1;

    exp_addr = RESET_PC;
    for (int i = 0; i < 16; i++) begin
      do_fetch(vecs[i].dly, vecs[i].stl, vecs[i].j, vecs[i].ji, vecs[i].b, vecs[i].bt);
      exp_addr = vecs[i].nxt;
    end

    for (int i = 0; i < 40; i++) begin
      logic        rj, rb;
      logic [25:0] rji;
      logic [31:0] rbt;
      int          rd, rs;
      rd  = $urandom_range(0, 3);
      rs  = $urandom_range(0, 2);
      rj  = ($urandom_range(0, 3) == 0);
      rb  = ($urandom_range(0, 2) == 0);
      rji = 26'($urandom);
      rbt = $urandom;
      rbt[1:0] = 2'b00;
      do_fetch(rd, rs, rj, rji, rb, rbt);
      exp_addr = ref_next(exp_addr, rj, rji, rb, rbt);
    end

    // Reset while a request is outstanding; a ready pulse inside reset must be ignored.
    begin
      int n;
      n = 0;
      while (!imem_req && n < 20) begin
        tick();
        n++;
      end
      chk("pre_rst_req", {31'b0, imem_req}, 32'd1);
      #2;
      rst_n = 1'b0;
      #1;
      chk("midrst_req", {31'b0, imem_req}, 32'd0);
      chk("midrst_valid", {31'b0, instr_valid}, 32'd0);
      imem_ready = 1'b1;
      imem_rdata = 32'hDEAD_BEEF;
      tick();
      imem_ready = 1'b0;
      chk("midrst_instr", instr, 32'd0);
      chk("midrst_addr", imem_addr, RESET_PC);
      rst_n = 1'b1;
      exp_addr = RESET_PC;
      do_fetch(0, 0, 1'b0, 26'h0, 1'b1, 32'h0000_0102);
    end

`ifdef FETCH_ALIGN_CHECK_EN
    begin
      bit quiet;
      chk("fault_set", {31'b0, fetch_fault}, 32'd1);
      quiet = 1;
      for (int i = 0; i < 10; i++) begin
        tick();
        if (imem_req || instr_valid || !fetch_fault) quiet = 0;
      end
      chk("halt_quiet", {31'b0, quiet}, 32'd1);
      rst_n = 1'b0;
      #1;
      chk("fault_clear", {31'b0, fetch_fault}, 32'd0);
      tick();
      rst_n = 1'b1;
      exp_addr = RESET_PC;
      do_fetch(0, 0, 1'b0, 26'h0, 1'b0, 32'h0);
    end
`else
    chk("no_fault", {31'b0, fetch_fault}, 32'd0);
    exp_addr = 32'h0000_0100;
    do_fetch(0, 0, 1'b0, 26'h0, 1'b0, 32'h0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end
endmodule
